// File: rtl/tcm_dma_pkg.sv
// Shared definitions for the TCM word-copy engine.
// Holds the copy FSM state type, the request tag layout
// (bit 10 = write, bit 9 = reserved zero, bits 8:0 = word index),
// the full-word byte strobe, and a tag builder.
package tcm_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_DONE
  } state_e;

  localparam int unsigned TAG_W      = 11;
  localparam int unsigned TAG_WR_BIT = 10;
  localparam int unsigned IDX_W      = 9;

  localparam logic [3:0] STRB_WORD = 4'hF;

  function automatic logic [TAG_W-1:0] make_tag(input logic is_wr, input logic [IDX_W-1:0] idx);
    logic [TAG_W-1:0] tag;
    tag                 = '0;
    tag[TAG_WR_BIT]     = is_wr;
    tag[IDX_W-1:0]      = idx;
    return tag;
  endfunction

endpackage

// File: rtl/tcm_dma_timeout.sv
// Ack-wait watchdog for the TCM word-copy engine.
// Loadable down-counter: load_i reloads LOAD_VALUE, en_i counts down,
// expired_o is high in the LOAD_VALUE-th enabled cycle after a load.
// Ports: clk_i, rst_i (sync, active-high), load_i, en_i, expired_o.
// Only built when TCM_DMA_TIMEOUT_EN is defined; the module body is
// guarded so the default build has no stray unused top-level module.
`ifdef TCM_DMA_TIMEOUT_EN
module tcm_dma_timeout #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned LOAD_VALUE = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LOAD_V = CNT_W'(LOAD_VALUE);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = LOAD_V;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - ONE;
    end
  end

  always_comb expired_o = en_i && (count_q == ONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`endif

// File: rtl/tcm_dma_copy.sv
// Single-channel word-copy engine on the mem_d request/ack port.
// A start pulse in IDLE latches word-aligned src/dst and a word count;
// each word is one read (RD_REQ/RD_WAIT) then one write (WR_REQ/WR_WAIT),
// one request outstanding. Error responses or tag mismatches abort the
// copy with a sticky error_o and a done_o pulse.
// Ports: clk_i, rst_i (sync, active-high), start_i, src_addr_i, dst_addr_i,
//        len_i, busy_o, done_o, error_o, mem_d_* initiator port.
// Optional: TCM_DMA_TIMEOUT_EN adds an ack watchdog of TIMEOUT_CYCLES.
module tcm_dma_copy
  import tcm_dma_pkg::*;
#(
  parameter int unsigned LEN_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [31:0]      mem_d_addr_o,
  output logic [31:0]      mem_d_data_wr_o,
  output logic             mem_d_rd_o,
  output logic [3:0]       mem_d_wr_o,
  output logic             mem_d_cacheable_o,
  output logic             mem_d_invalidate_o,
  output logic             mem_d_writeback_o,
  output logic             mem_d_flush_o,
  output logic [10:0]      mem_d_req_tag_o,
  input  logic [31:0]      mem_d_data_rd_i,
  input  logic             mem_d_accept_i,
  input  logic             mem_d_ack_i,
  input  logic             mem_d_error_i,
  input  logic [10:0]      mem_d_resp_tag_i
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_e             state_q, state_d;
  logic [31:0]        src_q, src_d;
  logic [31:0]        dst_q, dst_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        data_q, data_d;
  logic               error_q, error_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rd_q, rd_d;
  logic [3:0]         wr_q, wr_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [TAG_W-1:0]   tag_q, tag_d;

  logic [TAG_W-1:0]   exp_tag;
  logic               resp_bad;
  logic               to_expired;

`ifdef TCM_DMA_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic to_load;
  logic to_en;

  // Reload on every REQ->WAIT hand-off so each wait gets a fresh budget.
  always_comb begin
    to_load = ((state_q == ST_RD_REQ) || (state_q == ST_WR_REQ)) && mem_d_accept_i;
    to_en   = (state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT);
  end

  tcm_dma_timeout #(
    .CNT_W      (TO_W),
    .LOAD_VALUE (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (to_load),
    .en_i      (to_en),
    .expired_o (to_expired)
  );
`else
  logic unused_timeout_cfg;
  always_comb unused_timeout_cfg = ^TIMEOUT_CYCLES;
  always_comb to_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    data_d  = data_q;
    error_d = error_q;

    exp_tag  = make_tag(state_q == ST_WR_WAIT, idx_q);
    resp_bad = mem_d_error_i || (mem_d_resp_tag_i != exp_tag);

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          src_d   = {src_addr_i[31:2], 2'b00};
          dst_d   = {dst_addr_i[31:2], 2'b00};
          rem_d   = len_i;
          idx_d   = '0;
          error_d = 1'b0;
          state_d = (len_i == '0) ? ST_DONE : ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (mem_d_accept_i) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (mem_d_ack_i) begin
          if (resp_bad) begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            data_d  = mem_d_data_rd_i;
            state_d = ST_WR_REQ;
          end
        end else if (to_expired) begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_WR_REQ: begin
        if (mem_d_accept_i) state_d = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (mem_d_ack_i) begin
          if (resp_bad) begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            src_d   = src_q + 32'd4;
            dst_d   = dst_q + 32'd4;
            idx_d   = idx_q + 9'd1;
            rem_d   = rem_q - LEN_ONE;
            state_d = (rem_q == LEN_ONE) ? ST_DONE : ST_RD_REQ;
          end
        end else if (to_expired) begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they appear registered
    // in the same cycle the FSM enters that state.
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    rd_d    = (state_d == ST_RD_REQ);
    wr_d    = (state_d == ST_WR_REQ) ? STRB_WORD : '0;
    addr_d  = '0;
    wdata_d = '0;
    tag_d   = '0;
    if (state_d == ST_RD_REQ) begin
      addr_d = src_d;
      tag_d  = make_tag(1'b0, idx_d);
    end else if (state_d == ST_WR_REQ) begin
      addr_d  = dst_d;
      wdata_d = data_d;
      tag_d   = make_tag(1'b1, idx_d);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      error_q <= error_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tag_q   <= tag_d;
    end
  end

  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign error_o            = error_q;
  assign mem_d_addr_o       = addr_q;
  assign mem_d_data_wr_o    = wdata_q;
  assign mem_d_rd_o         = rd_q;
  assign mem_d_wr_o         = wr_q;
  assign mem_d_req_tag_o    = tag_q;
  assign mem_d_cacheable_o  = 1'b0;
  assign mem_d_invalidate_o = 1'b0;
  assign mem_d_writeback_o  = 1'b0;
  assign mem_d_flush_o      = 1'b0;

endmodule

// File: tb/tb_tcm_dma_copy.sv
// Self-checking bench for tcm_dma_copy: table of copy scenarios run
// against a bench-side responder, plus hand-written reset sequences.
module tb_tcm_dma_copy;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len;
  logic        busy, done, error;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_rd;
  logic [3:0]  m_wr;
  logic        m_cacheable, m_invalidate, m_writeback, m_flush;
  logic [10:0] m_req_tag, m_resp_tag;
  logic        m_accept, m_ack, m_error;

  tcm_dma_copy #(.LEN_W(16), .TIMEOUT_CYCLES(255)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .start_i            (start),
    .src_addr_i         (src_addr),
    .dst_addr_i         (dst_addr),
    .len_i              (len),
    .busy_o             (busy),
    .done_o             (done),
    .error_o            (error),
    .mem_d_addr_o       (m_addr),
    .mem_d_data_wr_o    (m_wdata),
    .mem_d_rd_o         (m_rd),
    .mem_d_wr_o         (m_wr),
    .mem_d_cacheable_o  (m_cacheable),
    .mem_d_invalidate_o (m_invalidate),
    .mem_d_writeback_o  (m_writeback),
    .mem_d_flush_o      (m_flush),
    .mem_d_req_tag_o    (m_req_tag),
    .mem_d_data_rd_i    (m_rdata),
    .mem_d_accept_i     (m_accept),
    .mem_d_ack_i        (m_ack),
    .mem_d_error_i      (m_error),
    .mem_d_resp_tag_i   (m_resp_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] model(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]};
  endfunction

  // Responder configuration and logs
  bit          manual;
  int          stall_rd, stall_n, err_wr, badtag_rd;
  int          rd_cnt, wr_cnt, req_cycles, stall_left, stall_seen, hold_viol;
  bit          ack_pending, pend_err;
  logic [31:0] pend_data, hold_addr;
  logic [10:0] pend_tag, hold_tag;
  logic [31:0] rd_log[$];
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];

  // Responder: accepts requests (optionally stalling one read) and acks
  // the cycle after accept, echoing the request tag.
  initial begin
    forever begin
      @(negedge clk);
      if (!manual) begin
        m_ack      = 1'b0;
        m_error    = 1'b0;
        m_accept   = 1'b0;
        if (ack_pending) begin
          m_ack       = 1'b1;
          m_rdata     = pend_data;
          m_resp_tag  = pend_tag;
          m_error     = pend_err;
          ack_pending = 1'b0;
        end
        if (m_rd || (m_wr != 4'h0)) begin
          req_cycles++;
          if (m_rd && (rd_cnt == stall_rd) && (stall_left > 0)) begin
            if (stall_left == stall_n) begin
              hold_addr = m_addr;
              hold_tag  = m_req_tag;
            end else if (m_addr !== hold_addr || m_req_tag !== hold_tag) begin
              hold_viol++;
            end
            stall_left--;
            stall_seen++;
          end else begin
            if (m_rd && stall_n > 0 && rd_cnt == stall_rd &&
                (m_addr !== hold_addr || m_req_tag !== hold_tag)) hold_viol++;
            m_accept    = 1'b1;
            ack_pending = 1'b1;
            pend_tag    = m_req_tag;
            pend_err    = 1'b0;
            pend_data   = 32'h0;
            if (m_rd) begin
              rd_log.push_back(m_addr);
              pend_data = model(m_addr);
              if (rd_cnt == badtag_rd) pend_tag = m_req_tag ^ 11'h001;
              rd_cnt++;
            end else begin
              wr_addr_log.push_back(m_addr);
              wr_data_log.push_back(m_wdata);
              pend_err = (wr_cnt == err_wr);
              wr_cnt++;
            end
          end
        end
      end
    end
  end

  typedef struct {
    string       name;
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    int          stall_rd;
    int          stall_n;
    int          err_wr;
    int          badtag_rd;
    bit          mid_start;
    int          exp_done;
    bit          exp_err;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int          done_cycle, done_count, busy_bad, tie_bad;
    logic        err_at_done, err_after, busy_after, rd_c1;
    logic [31:0] src_al, dst_al, ea;
    stall_rd   = v.stall_rd;
    stall_n    = v.stall_n;
    stall_left = v.stall_n;
    err_wr     = v.err_wr;
    badtag_rd  = v.badtag_rd;
    rd_cnt = 0; wr_cnt = 0; req_cycles = 0; stall_seen = 0; hold_viol = 0;
    rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
    done_cycle = -1; done_count = 0; busy_bad = 0; tie_bad = 0;
    err_at_done = 1'bx; err_after = 1'bx; busy_after = 1'bx; rd_c1 = 1'b0;

    @(negedge clk);
    start    = 1'b1;
    src_addr = v.src;
    dst_addr = v.dst;
    len      = 16'(v.len);
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (cyc == 1) rd_c1 = m_rd;
      if (v.mid_start && cyc == 3) begin
        start = 1'b1; len = 16'd5; src_addr = 32'h0000_1000; dst_addr = 32'h0000_2000;
      end
      if (cyc == 4) start = 1'b0;
      if (m_cacheable || m_invalidate || m_writeback || m_flush) tie_bad++;
      if (done_cycle > 0 && cyc == done_cycle + 1) begin
        busy_after = busy;
        err_after  = error;
        if (done) done_count++;
        break;
      end
      if (done) begin
        done_count++;
        done_cycle  = cyc;
        err_at_done = error;
      end
      if ((done_cycle < 0 || cyc == done_cycle) && !busy) busy_bad++;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);

    check({v.name, ".done_cycle"}, 32'(done_cycle), 32'(v.exp_done));
    check({v.name, ".done_pulses"}, 32'(done_count), 32'd1);
    check({v.name, ".busy_window"}, 32'(busy_bad), 32'd0);
    check({v.name, ".error_at_done"}, {31'd0, err_at_done}, {31'd0, v.exp_err});
    check({v.name, ".error_sticky"}, {31'd0, err_after}, {31'd0, v.exp_err});
    check({v.name, ".busy_after"}, {31'd0, busy_after}, 32'd0);
    check({v.name, ".tieoffs"}, 32'(tie_bad), 32'd0);
    if (v.len != 0) check({v.name, ".rd_first_cycle"}, {31'd0, rd_c1}, 32'd1);
    check({v.name, ".n_reads"}, 32'(rd_log.size()), 32'(v.exp_rd));
    check({v.name, ".n_writes"}, 32'(wr_addr_log.size()), 32'(v.exp_wr));
    check({v.name, ".req_cycles"}, 32'(req_cycles), 32'(v.exp_rd + v.exp_wr + v.stall_n));
    src_al = {v.src[31:2], 2'b00};
    dst_al = {v.dst[31:2], 2'b00};
    for (int i = 0; i < v.exp_rd && i < rd_log.size(); i++) begin
      ea = src_al + 32'(4 * i);
      check($sformatf("%s.rd_addr%0d", v.name, i), rd_log[i], ea);
    end
    for (int i = 0; i < v.exp_wr && i < wr_addr_log.size(); i++) begin
      ea = dst_al + 32'(4 * i);
      check($sformatf("%s.wr_addr%0d", v.name, i), wr_addr_log[i], ea);
      ea = model(src_al + 32'(4 * i));
      check($sformatf("%s.wr_data%0d", v.name, i), wr_data_log[i], ea);
    end
    if (v.stall_n > 0) begin
      check({v.name, ".stall_cycles"}, 32'(stall_seen), 32'(v.stall_n));
      check({v.name, ".stall_hold"}, 32'(hold_viol), 32'd0);
    end
  endtask

  vec_t vecs[7];
  int   idle_bad;

  initial begin
    //            name       src           dst           len stR stN  eW  bT  mid done err rd wr
    vecs[0] = '{"basic",   32'h2000_0000, 32'h2000_0100, 3, -1, 0, -1, -1, 0, 13, 0, 3, 3};
    vecs[1] = '{"zerolen", 32'h2000_0000, 32'h2000_0100, 0, -1, 0, -1, -1, 0,  1, 0, 0, 0};
    vecs[2] = '{"stall",   32'h2000_0040, 32'h2000_0200, 3,  1, 5, -1, -1, 0, 18, 0, 3, 3};
    vecs[3] = '{"errwr",   32'h2000_0000, 32'h2000_0300, 3, -1, 0,  1, -1, 0,  9, 1, 2, 2};
    vecs[4] = '{"wrap",    32'hFFFF_FFFC, 32'h0000_0100, 2, -1, 0, -1, -1, 1,  9, 0, 2, 2};
    vecs[5] = '{"unalign", 32'h1000_0013, 32'h3000_0002, 1, -1, 0, -1, -1, 0,  5, 0, 1, 1};
    vecs[6] = '{"badtag",  32'h2000_0080, 32'h2000_0400, 3, -1, 0, -1,  1, 0,  7, 1, 2, 1};

    manual = 1'b0; ack_pending = 1'b0;
    stall_rd = -1; stall_n = 0; err_wr = -1; badtag_rd = -1;
    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    m_accept = 1'b0; m_ack = 1'b0; m_error = 1'b0; m_rdata = '0; m_resp_tag = '0;
    repeat (3) @(negedge clk);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.done", {31'd0, done}, 32'd0);
    check("rst.error", {31'd0, error}, 32'd0);
    check("rst.rd", {31'd0, m_rd}, 32'd0);
    check("rst.wr", {28'd0, m_wr}, 32'd0);
    check("rst.addr", m_addr, 32'd0);
    check("rst.wdata", m_wdata, 32'd0);
    check("rst.tag", {21'd0, m_req_tag}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Sticky error from the last aborted copy is cleared by reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("idle_rst.error", {31'd0, error}, 32'd0);

    // Reset while waiting for a read ack; the stale ack must be ignored.
    manual = 1'b1;
    @(negedge clk);
    m_accept = 1'b0; m_ack = 1'b0; m_error = 1'b0;
    start = 1'b1; src_addr = 32'h2000_0500; dst_addr = 32'h2000_0600; len = 16'd2;
    @(negedge clk);
    start = 1'b0;
    check("rstwait.rd_req", {31'd0, m_rd}, 32'd1);
    check("rstwait.rd_addr", m_addr, 32'h2000_0500);
    m_accept = 1'b1;
    @(negedge clk);
    m_accept = 1'b0;
    check("rstwait.in_wait_busy", {31'd0, busy}, 32'd1);
    check("rstwait.in_wait_rd", {31'd0, m_rd}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstwait.busy", {31'd0, busy}, 32'd0);
    check("rstwait.done", {31'd0, done}, 32'd0);
    check("rstwait.rd", {31'd0, m_rd}, 32'd0);
    check("rstwait.addr", m_addr, 32'd0);
    check("rstwait.tag", {21'd0, m_req_tag}, 32'd0);
    m_ack = 1'b1; m_resp_tag = 11'h000; m_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    m_ack = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy || done || error || m_rd || (m_wr != 4'h0)) idle_bad++;
      @(negedge clk);
    end
    check("rstwait.stale_ack_ignored", 32'(idle_bad), 32'd0);
    manual = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
